// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control with data-wait and halt FSM.
// Outputs are combinational from state and inputs; only the state and counters are registered.
module hazard_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        ex_mem_dREN,
    input  logic        ex_mem_dWEN,
    input  logic        ex_mem_pcsrc,
    input  logic        id_ex_dREN,
    input  logic [4:0]  id_ex_regtbw,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        mem_wb_halt,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        stall_inc, flush_inc;
    logic        dpend, loaduse;

    assign dpend   = (ex_mem_dREN | ex_mem_dWEN) & ~dhit;
    assign loaduse = id_ex_dREN & (id_ex_regtbw != 5'd0) &
                     ((id_ex_regtbw == if_id_rs) | (id_ex_regtbw == if_id_rt));

    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!nRST) begin
            state_d = RUN;
        end else if (state_q == HALTED) begin
            halted = 1'b1;
        end else if (mem_wb_halt) begin
            halted  = 1'b1;
            state_d = HALTED;
        end else if (dpend) begin
            state_d   = DWAIT;
            stall_inc = 1'b1;
        end else begin
            state_d   = RUN;
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (ex_mem_pcsrc) begin
                // wrong-path instructions are squashed even if the fetch is still outstanding
                pc_en        = ihit;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                flush_inc    = 1'b1;
            end else if (loaduse) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
            stall_inc = ~pc_en;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (stall_inc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_inc && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors feed a scoreboard queue; a negedge monitor checks the DUT.
module tb_hazard_unit;
    logic        CLK = 1'b0;
    logic        nRST, ihit, dhit, ex_mem_dREN, ex_mem_dWEN, ex_mem_pcsrc, id_ex_dREN, mem_wb_halt;
    logic [4:0]  id_ex_regtbw, if_id_rs, if_id_rt;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        string       n;
        logic [8:0]  ctl;
        logic [31:0] s;
        logic [31:0] f;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    logic [8:0] act;

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .ex_mem_dREN(ex_mem_dREN), .ex_mem_dWEN(ex_mem_dWEN), .ex_mem_pcsrc(ex_mem_pcsrc),
        .id_ex_dREN(id_ex_dREN), .id_ex_regtbw(id_ex_regtbw),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .mem_wb_halt(mem_wb_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    // ctl = {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, halted}
    assign act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, halted};

    always @(negedge CLK) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if (act !== e.ctl || stall_cnt !== e.s || flush_cnt !== e.f) begin
                fails++;
                $display("FAIL %s: ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                         e.n, act, stall_cnt, flush_cnt, e.ctl, e.s, e.f);
            end
        end
    end

    // inputs packed as {nRST, ihit, dhit, dREN, dWEN, pcsrc, id_ex_dREN, halt}
    task automatic v(input string n, input logic [7:0] in, input logic [4:0] tbw,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [8:0] ctl, input int s, input int f);
        exp_t x;
        @(posedge CLK);
        #1;
        {nRST, ihit, dhit, ex_mem_dREN, ex_mem_dWEN, ex_mem_pcsrc, id_ex_dREN, mem_wb_halt} = in;
        id_ex_regtbw = tbw;
        if_id_rs     = rs;
        if_id_rt     = rt;
        x.n = n; x.ctl = ctl; x.s = s; x.f = f;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {nRST, ihit, dhit, ex_mem_dREN, ex_mem_dWEN, ex_mem_pcsrc, id_ex_dREN, mem_wb_halt} = 8'b0;
        id_ex_regtbw = 0; if_id_rs = 0; if_id_rt = 0;
        v("reset",          8'b0100_0000, 0, 0, 0, 9'b00000_000_0, 0, 0);
        v("normal",         8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 0, 0);
        v("loaduse_rs",     8'b1100_0010, 5, 5, 1, 9'b00111_010_0, 0, 0);
        v("after_loaduse",  8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 1, 0);
        v("loaduse_rt",     8'b1100_0010, 7, 3, 7, 9'b00111_010_0, 1, 0);
        v("loaduse_r0",     8'b1100_0010, 0, 0, 0, 9'b11111_000_0, 2, 0);
        v("imiss",          8'b1000_0000, 0, 0, 0, 9'b01111_100_0, 2, 0);
        v("dwait1",         8'b1101_0000, 0, 0, 0, 9'b00000_000_0, 3, 0);
        v("dwait2",         8'b1101_0000, 0, 0, 0, 9'b00000_000_0, 4, 0);
        v("dwait3",         8'b1101_0000, 0, 0, 0, 9'b00000_000_0, 5, 0);
        v("dhit_release",   8'b1111_0000, 0, 0, 0, 9'b11111_000_0, 6, 0);
        v("post_release",   8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 6, 0);
        v("branch_ld",      8'b1100_0110, 5, 5, 0, 9'b11111_111_0, 6, 0);
        v("after_branch",   8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 6, 1);
        v("branch_imiss",   8'b1000_0100, 0, 0, 0, 9'b01111_111_0, 6, 1);
        v("branch_dpend",   8'b1100_1100, 0, 0, 0, 9'b00000_000_0, 7, 2);
        v("dwait_loaduse",  8'b1110_1010, 9, 9, 0, 9'b00111_010_0, 8, 2);
        v("normal2",        8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 9, 2);
        v("halt_req",       8'b1100_0101, 0, 0, 0, 9'b00000_000_1, 9, 2);
        v("halted1",        8'b1100_0000, 0, 0, 0, 9'b00000_000_1, 9, 2);
        v("halted2",        8'b1001_0000, 0, 0, 0, 9'b00000_000_1, 9, 2);
        v("reset_halted",   8'b0100_0000, 0, 0, 0, 9'b00000_000_0, 0, 0);
        v("run_after_rst",  8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 0, 0);
        v("dwait_a",        8'b1101_0000, 0, 0, 0, 9'b00000_000_0, 0, 0);
        v("dwait_b",        8'b1101_0000, 0, 0, 0, 9'b00000_000_0, 1, 0);
        v("reset_dwait",    8'b0101_0000, 0, 0, 0, 9'b00000_000_0, 0, 0);
        v("run_after_rst2", 8'b1100_0000, 0, 0, 0, 9'b11111_000_0, 0, 0);
        v("normal3",        8'b1100_0010, 4, 5, 6, 9'b11111_000_0, 0, 0);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge CLK);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
